// File: rtl/key_ctrl_if.sv
// Bundle of the pushbutton inputs, the debounced key events and the mode toggles.
// The master side drives the raw keys; the slave side (key_ctrl) produces everything else.
interface key_ctrl_if;
    logic [1:0] key_n;
    logic [1:0] pressed;
    logic [1:0] press;
    logic [1:0] short_press;
    logic [1:0] long_press;
    logic       clk_sel;
    logic       run;
    logic       clear;

    modport master (
        output key_n,
        input  pressed, press, short_press, long_press, clk_sel, run, clear
    );

    modport slave (
        input  key_n,
        output pressed, press, short_press, long_press, clk_sel, run, clear
    );
endinterface

// File: rtl/key_ctrl.sv
// Two-key pushbutton front end: synchronise, debounce, classify short/long presses
// and keep the clock-rate select and run/stop toggles.
module key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DB_W            = 17,
    parameter int HOLD_CYCLES     = 10000000,
    parameter int HOLD_W          = 24
) (
    input  logic       clock,
    input  logic       reset,
    key_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHORT,
        LONG
    } key_state_e;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        stable;
    logic [DB_W-1:0]   db_cnt [2];

    key_state_e        state_q [2];
    key_state_e        state_d [2];
    logic [HOLD_W-1:0] hold_q  [2];
    logic [HOLD_W-1:0] hold_d  [2];
    logic [1:0]        press_d;
    logic [1:0]        short_d;
    logic [1:0]        long_d;

    // Any return of the synchronised level to the stable one restarts qualification,
    // so the counter only reaches its terminal value on an unbroken run.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            stable <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        press_d = '0;
        short_d = '0;
        long_d  = '0;
        for (int i = 0; i < 2; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (!stable[i]) begin
                        state_d[i] = SHORT;
                        hold_d[i]  = '0;
                        press_d[i] = 1'b1;
                    end
                end
                SHORT: begin
                    if (stable[i]) begin
                        state_d[i] = IDLE;
                        hold_d[i]  = '0;
                        short_d[i] = 1'b1;
                    end else if (hold_q[i] == HOLD_LAST) begin
                        state_d[i] = LONG;
                        hold_d[i]  = '0;
                        long_d[i]  = 1'b1;
                    end else begin
                        hold_d[i] = hold_q[i] + HOLD_W'(1);
                    end
                end
                LONG: begin
                    if (stable[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    hold_d[i]  = '0;
                end
            endcase
        end
    end

    // Event pulses are registered on the same edge as the FSM transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                hold_q[i]  <= '0;
            end
            bus.pressed     <= '0;
            bus.press       <= '0;
            bus.short_press <= '0;
            bus.long_press  <= '0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            bus.pressed     <= ~stable;
            bus.press       <= press_d;
            bus.short_press <= short_d;
            bus.long_press  <= long_d;
        end
    end

    // A long press on key 0 stops the counters as well as clearing them.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.clk_sel <= 1'b0;
            bus.run     <= 1'b0;
            bus.clear   <= 1'b0;
        end else begin
            bus.clk_sel <= bus.clk_sel ^ bus.short_press[1];
            bus.clear   <= bus.long_press[0];
            if (bus.long_press[0]) begin
                bus.run <= 1'b0;
            end else if (bus.short_press[0]) begin
                bus.run <= ~bus.run;
            end
        end
    end

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl with short debounce/hold constants so every
// timing relationship can be checked cycle by cycle.
module tb_key_ctrl;

    logic clock;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   press_cnt [2] = '{0, 0};
    int   short_cnt [2] = '{0, 0};
    int   long_cnt  [2] = '{0, 0};
    int   clear_cnt     = 0;

    key_ctrl_if bus ();

    key_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DB_W           (3),
        .HOLD_CYCLES    (16),
        .HOLD_W         (5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                press_cnt[i] += int'(bus.press[i]);
                short_cnt[i] += int'(bus.short_press[i]);
                long_cnt[i]  += int'(bus.long_press[i]);
            end
            clear_cnt += int'(bus.clear);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.key_n = 2'b11;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        repeat (3) step();
        outs = {bus.pressed, bus.press, bus.clk_sel, bus.run, bus.clear};
        vectors++;
        if (outs !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_levels: got %b want 0000000", outs);
        end
        vectors++;
        if ({bus.short_press, bus.long_press} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_pulses: got %b want 0000", {bus.short_press, bus.long_press});
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            vectors++;
            if ({bus.press, bus.short_press, bus.long_press, bus.clear} !== 7'b0) begin
                miscompares++;
                $display("[TB] FAIL post_reset_quiet k=%0d: got %b want 0000000", k,
                         {bus.press, bus.short_press, bus.long_press, bus.clear});
            end
        end
    endtask

    task automatic test_bounce();
        int p0;
        logic [1:0] bursts [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
        int lens [4] = '{3, 1, 2, 1};
        p0 = press_cnt[0];
        for (int b = 0; b < 4; b++) begin
            bus.key_n = bursts[b];
            for (int k = 0; k < lens[b]; k++) begin
                step();
                vectors++;
                if (bus.press !== 2'b00 || bus.pressed !== 2'b00) begin
                    miscompares++;
                    $display("[TB] FAIL bounce_quiet b=%0d: press %b pressed %b want 00 00", b, bus.press, bus.pressed);
                end
            end
        end
        bus.key_n = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            step();
            vectors++;
            if (bus.press[0] !== (k == 7)) begin
                miscompares++;
                $display("[TB] FAIL bounce_press k=%0d: got %b want %b", k, bus.press[0], (k == 7));
            end
            vectors++;
            if (bus.pressed[0] !== (k >= 7)) begin
                miscompares++;
                $display("[TB] FAIL bounce_pressed k=%0d: got %b want %b", k, bus.pressed[0], (k >= 7));
            end
        end
        bus.key_n = 2'b11;
        repeat (10) step();
        vectors++;
        if (press_cnt[0] - p0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL bounce_press_count: got %0d want 1", press_cnt[0] - p0);
        end
    endtask

    task automatic test_short_toggle();
        int p0;
        int s0;
        do_reset();
        p0 = press_cnt[0];
        s0 = short_cnt[0];
        for (int rep = 0; rep < 2; rep++) begin
            bus.key_n = 2'b10;
            repeat (8) step();
            bus.key_n = 2'b11;
            for (int k = 1; k <= 12; k++) begin
                step();
                vectors++;
                if (bus.short_press[0] !== (k == 7)) begin
                    miscompares++;
                    $display("[TB] FAIL short_pulse rep=%0d k=%0d: got %b want %b", rep, k, bus.short_press[0], (k == 7));
                end
                vectors++;
                if (bus.run !== ((k >= 8) ? (rep == 0) : (rep == 1))) begin
                    miscompares++;
                    $display("[TB] FAIL short_run rep=%0d k=%0d: got %b want %b", rep, k, bus.run,
                             ((k >= 8) ? (rep == 0) : (rep == 1)));
                end
            end
        end
        vectors++;
        if (press_cnt[0] - p0 !== 2 || short_cnt[0] - s0 !== 2) begin
            miscompares++;
            $display("[TB] FAIL short_counts: press %0d short %0d want 2 2", press_cnt[0] - p0, short_cnt[0] - s0);
        end
    endtask

    task automatic test_long_press();
        int s0;
        int l0;
        int c0;
        do_reset();
        bus.key_n = 2'b10;
        repeat (8) step();
        bus.key_n = 2'b11;
        repeat (12) step();
        vectors++;
        if (bus.run !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL long_pre_run: got %b want 1", bus.run);
        end
        s0 = short_cnt[0];
        l0 = long_cnt[0];
        c0 = clear_cnt;
        bus.key_n = 2'b10;
        for (int k = 1; k <= 30; k++) begin
            step();
            vectors++;
            if (bus.press[0] !== (k == 7) || bus.long_press[0] !== (k == 23)) begin
                miscompares++;
                $display("[TB] FAIL long_timing k=%0d: press %b long %b want %b %b", k,
                         bus.press[0], bus.long_press[0], (k == 7), (k == 23));
            end
            vectors++;
            if (bus.clear !== (k == 24) || bus.run !== (k < 24)) begin
                miscompares++;
                $display("[TB] FAIL long_action k=%0d: clear %b run %b want %b %b", k,
                         bus.clear, bus.run, (k == 24), (k < 24));
            end
        end
        bus.key_n = 2'b11;
        repeat (12) step();
        vectors++;
        if (short_cnt[0] - s0 !== 0 || long_cnt[0] - l0 !== 1 || clear_cnt - c0 !== 1 || bus.run !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL long_release: short %0d long %0d clear %0d run %b want 0 1 1 0",
                     short_cnt[0] - s0, long_cnt[0] - l0, clear_cnt - c0, bus.run);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.key_n = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if (bus.press !== ((k == 7) ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("[TB] FAIL both_press k=%0d: got %b want %b", k, bus.press, ((k == 7) ? 2'b11 : 2'b00));
            end
        end
        bus.key_n = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            step();
            vectors++;
            if (bus.short_press !== ((k == 7) ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("[TB] FAIL both_short k=%0d: got %b want %b", k, bus.short_press, ((k == 7) ? 2'b11 : 2'b00));
            end
            vectors++;
            if ({bus.clk_sel, bus.run} !== ((k >= 8) ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("[TB] FAIL both_toggle k=%0d: got %b want %b", k, {bus.clk_sel, bus.run},
                         ((k >= 8) ? 2'b11 : 2'b00));
            end
        end
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        bus.key_n = 2'b01;
        repeat (10) step();
        vectors++;
        if (bus.pressed !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL midreset_held: got %b want 10", bus.pressed);
        end
        reset = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            vectors++;
            if ({bus.pressed, bus.press, bus.short_press, bus.long_press, bus.clk_sel, bus.clear} !== 10'b0) begin
                miscompares++;
                $display("[TB] FAIL midreset_during k=%0d: got %b want 0", k,
                         {bus.pressed, bus.press, bus.short_press, bus.long_press, bus.clk_sel, bus.clear});
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            vectors++;
            if (bus.press !== ((k == 7) ? 2'b10 : 2'b00) || bus.short_press !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL midreset_requal k=%0d: press %b short %b want %b 00", k,
                         bus.press, bus.short_press, ((k == 7) ? 2'b10 : 2'b00));
            end
            vectors++;
            if (bus.pressed[1] !== (k >= 7) || bus.clk_sel !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midreset_level k=%0d: pressed %b clk_sel %b want %b 0", k,
                         bus.pressed[1], bus.clk_sel, (k >= 7));
            end
        end
        bus.key_n = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            step();
            vectors++;
            if (bus.short_press[1] !== (k == 7) || bus.clk_sel !== (k >= 8)) begin
                miscompares++;
                $display("[TB] FAIL midreset_release k=%0d: short %b clk_sel %b want %b %b", k,
                         bus.short_press[1], bus.clk_sel, (k == 7), (k >= 8));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.key_n = 2'b11;
        test_reset();
        test_bounce();
        test_short_toggle();
        test_long_press();
        test_simultaneous();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
